// File: rtl/pipelined_divider_if.sv
// Operand/result bundle for pipelined_divider.
// The master drives operands; the slave (the divider) returns results.
interface pipelined_divider_if #(
  parameter int WIDTHN = 8,
  parameter int WIDTHD = 4
);
  logic              in_valid;
  logic [WIDTHN-1:0] dividend;
  logic [WIDTHD-1:0] divisor;
  logic              out_valid;
  logic [WIDTHN-1:0] quotient;
  logic [WIDTHD-1:0] remainder;
  logic              div_by_zero;

  modport master (
    output in_valid, dividend, divisor,
    input  out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor,
    output out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/pipelined_divider.sv
// Fully pipelined restoring divider, one quotient bit per registered stage.
// Define PIPELINED_DIVIDER_SIGNED_EN for two's-complement operands (adds input and output stages).
module pipelined_divider #(
  parameter int WIDTHN = 8,
  parameter int WIDTHD = 4
) (
  input logic                clk,
  input logic                rst,
  input logic                en,
  pipelined_divider_if.slave bus
);
  localparam int L = WIDTHN - 1;

  logic              core_valid;
  logic              core_dbz;
  logic [WIDTHN-1:0] core_num;
  logic [WIDTHD-1:0] core_dvs;

  // num_q holds the unconsumed dividend bits on top and resolved quotient bits below
  logic              valid_q [WIDTHN];
  logic              dbz_q   [WIDTHN];
  logic [WIDTHN-1:0] num_q   [WIDTHN];
  logic [WIDTHD-1:0] dvs_q   [WIDTHN];
  logic [WIDTHD-1:0] rem_q   [WIDTHN];

  logic              v_in    [WIDTHN];
  logic              z_in    [WIDTHN];
  logic [WIDTHN-1:0] n_in    [WIDTHN];
  logic [WIDTHD-1:0] d_in    [WIDTHN];
  logic [WIDTHD-1:0] r_in    [WIDTHN];
  logic [WIDTHD:0]   trial   [WIDTHN];
  logic              ge      [WIDTHN];
  logic [WIDTHN-1:0] num_d   [WIDTHN];
  logic [WIDTHD-1:0] rem_d   [WIDTHN];

`ifdef PIPELINED_DIVIDER_SIGNED_EN
  logic [1:0]        core_sgn;
  logic [1:0]        sgn_q   [WIDTHN];
  logic [1:0]        s_in    [WIDTHN];

  logic              in_valid_q;
  logic              in_dbz_q;
  logic [1:0]        in_sgn_q;
  logic [WIDTHN-1:0] in_num_q;
  logic [WIDTHD-1:0] in_dvs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q <= 1'b0;
      in_dbz_q   <= 1'b0;
      in_sgn_q   <= '0;
      in_num_q   <= '0;
      in_dvs_q   <= '0;
    end else if (en) begin
      in_valid_q <= bus.in_valid;
      in_dbz_q   <= (bus.divisor == '0);
      in_sgn_q   <= {bus.dividend[WIDTHN-1], bus.divisor[WIDTHD-1]};
      in_num_q   <= bus.dividend[WIDTHN-1] ? -bus.dividend : bus.dividend;
      in_dvs_q   <= bus.divisor[WIDTHD-1] ? -bus.divisor : bus.divisor;
    end
  end

  assign core_valid = in_valid_q;
  assign core_dbz   = in_dbz_q;
  assign core_sgn   = in_sgn_q;
  assign core_num   = in_num_q;
  assign core_dvs   = in_dvs_q;
`else
  assign core_valid = bus.in_valid;
  assign core_dbz   = (bus.divisor == '0);
  assign core_num   = bus.dividend;
  assign core_dvs   = bus.divisor;
`endif

  // A zero divisor always passes the compare, which yields the all-ones quotient naturally
  always_comb begin
    v_in[0] = core_valid;
    z_in[0] = core_dbz;
    n_in[0] = core_num;
    d_in[0] = core_dvs;
    r_in[0] = '0;
`ifdef PIPELINED_DIVIDER_SIGNED_EN
    s_in[0] = core_sgn;
`endif
    for (int k = 1; k < WIDTHN; k++) begin
      v_in[k] = valid_q[k-1];
      z_in[k] = dbz_q[k-1];
      n_in[k] = num_q[k-1];
      d_in[k] = dvs_q[k-1];
      r_in[k] = rem_q[k-1];
`ifdef PIPELINED_DIVIDER_SIGNED_EN
      s_in[k] = sgn_q[k-1];
`endif
    end
    for (int k = 0; k < WIDTHN; k++) begin
      trial[k] = {r_in[k], n_in[k][WIDTHN-1]};
      ge[k]    = (trial[k] >= {1'b0, d_in[k]});
      rem_d[k] = ge[k] ? WIDTHD'(trial[k] - {1'b0, d_in[k]}) : WIDTHD'(trial[k]);
      num_d[k] = (n_in[k] << 1) | WIDTHN'(ge[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < WIDTHN; k++) begin
        valid_q[k] <= 1'b0;
        dbz_q[k]   <= 1'b0;
        num_q[k]   <= '0;
        dvs_q[k]   <= '0;
        rem_q[k]   <= '0;
`ifdef PIPELINED_DIVIDER_SIGNED_EN
        sgn_q[k]   <= '0;
`endif
      end
    end else if (en) begin
      for (int k = 0; k < WIDTHN; k++) begin
        valid_q[k] <= v_in[k];
        dbz_q[k]   <= z_in[k];
        num_q[k]   <= num_d[k];
        dvs_q[k]   <= d_in[k];
        rem_q[k]   <= rem_d[k];
`ifdef PIPELINED_DIVIDER_SIGNED_EN
        sgn_q[k]   <= s_in[k];
`endif
      end
    end
  end

`ifdef PIPELINED_DIVIDER_SIGNED_EN
  logic              out_valid_q;
  logic              out_dbz_q;
  logic [WIDTHN-1:0] out_quo_q;
  logic [WIDTHD-1:0] out_rem_q;

  // Remainder follows the dividend's sign; a zero divisor forces quotient -1 regardless of signs
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_dbz_q   <= 1'b0;
      out_quo_q   <= '0;
      out_rem_q   <= '0;
    end else if (en) begin
      out_valid_q <= valid_q[L];
      out_dbz_q   <= dbz_q[L];
      out_quo_q   <= dbz_q[L] ? '1 :
                     ((sgn_q[L][1] ^ sgn_q[L][0]) ? -num_q[L] : num_q[L]);
      out_rem_q   <= sgn_q[L][1] ? -rem_q[L] : rem_q[L];
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.div_by_zero = out_dbz_q;
  assign bus.quotient    = out_quo_q;
  assign bus.remainder   = out_rem_q;
`else
  assign bus.out_valid   = valid_q[L];
  assign bus.div_by_zero = dbz_q[L];
  assign bus.quotient    = num_q[L];
  assign bus.remainder   = rem_q[L];
`endif
endmodule

// File: tb/tb_pipelined_divider.sv
// Self-checking bench for pipelined_divider: vector table plus stall/reset sequences.
// Signed vectors are used when PIPELINED_DIVIDER_SIGNED_EN is defined.
module tb_pipelined_divider;
  localparam int WN = 8;
  localparam int WD = 4;
`ifdef PIPELINED_DIVIDER_SIGNED_EN
  localparam int LAT = WN + 2;
`else
  localparam int LAT = WN;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en;

  pipelined_divider_if #(.WIDTHN(WN), .WIDTHD(WD)) bus ();

  pipelined_divider #(.WIDTHN(WN), .WIDTHD(WD)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WN-1:0] n;
    logic [WD-1:0] d;
    logic [WN-1:0] q;
    logic [WD-1:0] r;
    logic          z;
  } vec_t;

  vec_t vecs[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [WN-1:0] n, input logic [WD-1:0] d);
    bus.in_valid = v;
    bus.dividend = n;
    bus.divisor  = d;
  endtask

  // Data fields are compared when a result is expected or when chk_data forces it (reset state)
  task automatic checkOutput(input string name, input logic ev, input logic [WN-1:0] q,
                             input logic [WD-1:0] r, input logic z, input logic chk_data);
    logic ok;
    tests_run++;
    ok = (bus.out_valid === ev);
    if (ev || chk_data)
      ok = ok && (bus.quotient === q) && (bus.remainder === r) && (bus.div_by_zero === z);
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL %s: got valid=%0b q=%0d r=%0d dbz=%0b, expected valid=%0b q=%0d r=%0d dbz=%0b",
               name, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, ev, q, r, z);
    end
  endtask

  initial begin
`ifdef PIPELINED_DIVIDER_SIGNED_EN
    vecs.push_back('{8'hF9, 4'h2, 8'hFD, 4'hF, 1'b0});
    vecs.push_back('{8'h80, 4'hF, 8'h80, 4'h0, 1'b0});
    vecs.push_back('{8'h07, 4'hE, 8'hFD, 4'h1, 1'b0});
    vecs.push_back('{8'h9C, 4'h7, 8'hF2, 4'hE, 1'b0});
    vecs.push_back('{8'h64, 4'h8, 8'hF4, 4'h4, 1'b0});
    vecs.push_back('{8'hFB, 4'h0, 8'hFF, 4'hB, 1'b1});
    vecs.push_back('{8'h32, 4'h6, 8'h08, 4'h2, 1'b0});
    vecs.push_back('{8'h80, 4'h7, 8'hEE, 4'hE, 1'b0});
`else
    vecs.push_back('{8'd200, 4'd7,  8'd28,  4'd4, 1'b0});
    vecs.push_back('{8'd255, 4'd1,  8'd255, 4'd0, 1'b0});
    vecs.push_back('{8'd5,   4'd9,  8'd0,   4'd5, 1'b0});
    vecs.push_back('{8'd128, 4'd15, 8'd8,   4'd8, 1'b0});
    vecs.push_back('{8'd100, 4'd0,  8'd255, 4'd4, 1'b1});
    vecs.push_back('{8'd9,   4'd3,  8'd3,   4'd0, 1'b0});
    vecs.push_back('{8'd50,  4'd6,  8'd8,   4'd2, 1'b0});
    vecs.push_back('{8'd0,   4'd5,  8'd0,   4'd0, 1'b0});
    vecs.push_back('{8'd15,  4'd15, 8'd1,   4'd0, 1'b0});
    vecs.push_back('{8'd254, 4'd13, 8'd19,  4'd7, 1'b0});
    vecs.push_back('{8'd1,   4'd0,  8'd255, 4'd1, 1'b1});
    vecs.push_back('{8'd7,   4'd8,  8'd0,   4'd7, 1'b0});
`endif

    en  = 1'b1;
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0);
    tick();
    tick();
    checkOutput("reset", 1'b0, '0, '0, 1'b0, 1'b1);
    rst = 1'b0;

    // Single op: exact latency, then a single valid cycle
    applyStimulus(1'b1, 8'd100, 4'd7);
    tick();
    applyStimulus(1'b0, '0, '0);
    for (int t = 2; t < LAT; t++) tick();
    checkOutput("single_early", 1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("single", 1'b1, 8'd14, 4'd2, 1'b0, 1'b0);
    tick();
    checkOutput("single_after", 1'b0, '0, '0, 1'b0, 1'b0);

    // Back-to-back stream; slot c at the output carries vector c-LAT+1
    for (int c = 0; c < vecs.size() + LAT; c++) begin
      int idx;
      if (c < vecs.size()) applyStimulus(1'b1, vecs[c].n, vecs[c].d);
      else                 applyStimulus(1'b0, '0, '0);
      tick();
      idx = c - LAT + 1;
      if (idx >= 0 && idx < vecs.size())
        checkOutput($sformatf("vec%0d", idx), 1'b1, vecs[idx].q, vecs[idx].r, vecs[idx].z, 1'b0);
      else
        checkOutput("vec_bubble", 1'b0, '0, '0, 1'b0, 1'b0);
    end

    // Stall for 5 cycles after 3 enabled cycles; garbage offered during the stall
    applyStimulus(1'b1, 8'd100, 4'd7);
    tick();
    applyStimulus(1'b0, '0, '0);
    tick();
    tick();
    en = 1'b0;
    applyStimulus(1'b1, 8'hAA, 4'h3);
    for (int t = 0; t < 5; t++) begin
      tick();
      checkOutput("stall_hold", 1'b0, '0, '0, 1'b0, 1'b0);
    end
    en = 1'b1;
    applyStimulus(1'b0, '0, '0);
    for (int t = 9; t < LAT + 5; t++) tick();
    checkOutput("stall_early", 1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("stall_result", 1'b1, 8'd14, 4'd2, 1'b0, 1'b0);
    en = 1'b0;
    applyStimulus(1'b1, 8'h55, 4'h2);
    for (int t = 0; t < 3; t++) begin
      tick();
      checkOutput("stall_frozen", 1'b1, 8'd14, 4'd2, 1'b0, 1'b0);
    end
    en = 1'b1;
    applyStimulus(1'b0, '0, '0);
    tick();
    checkOutput("stall_drain", 1'b0, '0, '0, 1'b0, 1'b0);

    // Reset mid-flight, asserted with en low to show rst wins
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(20 + i), 4'd3);
      tick();
    end
    applyStimulus(1'b0, '0, '0);
    rst = 1'b1;
    en  = 1'b0;
    tick();
    rst = 1'b0;
    en  = 1'b1;
    checkOutput("midreset_zero", 1'b0, '0, '0, 1'b0, 1'b1);
    for (int t = 0; t < LAT + 2; t++) begin
      tick();
      checkOutput("midreset_empty", 1'b0, '0, '0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'd50, 4'd6);
    tick();
    applyStimulus(1'b0, '0, '0);
    for (int t = 2; t < LAT; t++) tick();
    checkOutput("fresh_early", 1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("fresh", 1'b1, 8'd8, 4'd2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
